regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Sequential reader for the pipeline's 32x32 register file. Walks a programmable address range through one spare combinational read port.
- Streams each (index, value) pair out over a valid/ready handshake to the FPGA debug sink (seven-segment or UART formatter).
- Never writes the register file. Sits beside the writeback path and does not stall the pipeline.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of registers. Equals 2**ADDR_W. Address arithmetic wraps modulo NUM_REGS.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan. Sampled only in IDLE.
- first  input  ADDR_W  first register index. Latched on an accepted start.
- last  input  ADDR_W  last register index, inclusive. Latched on an accepted start.
- rd_addr  output  ADDR_W  address to the register file's spare read port.
- rd_data  input  DATA_W  combinational read data returned for rd_addr.
- out_valid  output  1  out_idx/out_data hold a valid word.
- out_ready  input  1  sink accepts the word when out_valid && out_ready.
- out_idx  output  ADDR_W  index of the presented register.
- out_data  output  DATA_W  captured value of that register.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- States: IDLE, READ, PRESENT, DONE. Encoding is binary, 2 bits.
- Reset (rst=1 at posedge), from any state including mid-scan:
  - state=IDLE, rd_addr=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0.
  - The latched first/last values are cleared to 0.
  - A scan interrupted by reset is abandoned; no done pulse is produced.
- IDLE:
  - start=1 latches first/last, sets rd_addr=first and busy=1, and moves to READ.
  - start=0 stays in IDLE.
- READ (one cycle):
  - out_data<=rd_data, out_idx<=rd_addr, out_valid<=1, then move to PRESENT.
  - The value is snapshotted here. Regfile writes after this edge do not alter the presented word.
- PRESENT:
  - out_valid=1; out_idx and out_data are held stable while out_ready=0, with no timeout.
  - On out_valid && out_ready:
    - out_valid<=0.
    - If out_idx==last_latched, move to DONE.
    - Otherwise rd_addr<=out_idx+1 modulo NUM_REGS, and move to READ.
- DONE (one cycle): done=1, busy<=0, then move to IDLE. done is 0 in all other states.
- Latency and throughput:
  - The first word becomes valid 2 cycles after the start edge.
  - Peak rate is 1 word per 2 cycles, with out_ready held high.
  - A range of N words completes with done asserted at cycle 2N+1 after start.
- Range rules:
  - first==last gives exactly one word.
  - first>last wraps through NUM_REGS-1 to 0. Word count = ((last-first) mod NUM_REGS)+1.
  - first=0, last=31 dumps all 32 registers in ascending order.
- start while busy (READ, PRESENT, DONE) is ignored. It is not queued, and first/last are not re-latched.
- start in the same cycle as rst: reset wins.
- Register 0 is dumped as whatever rd_data returns (0 by regfile contract). It receives no special casing.
- Data written to the regfile in the same cycle as READ is captured with the regfile's pre-edge value. The block does not bypass.

Decomposition:
- Shared package holds the state encoding constants (S_IDLE=0, S_READ=1, S_PRESENT=2, S_DONE=3) and ADDR_W/DATA_W defaults shared with the regfile.
- The index increment-with-wrap is small enough to stay inline.
- One natural sub-module: regfile_dump_out_reg. It is the output holding register for out_valid/out_idx/out_data with load/clear controls, and is reusable for other debug taps.

Test Plan:
- Full dump: regfile[i]=i*0x11111111, start with first=0, last=31, out_ready=1. Expect 32 words, idx 0..31, data matching, done pulse at cycle 65 after start, busy low the cycle after.
- Single word: first=last=7, regfile[7]=0xDEADBEEF. Expect exactly one word (7, 0xDEADBEEF), then done; no further out_valid.
- Wrap: first=30, last=1. Expect idx order 30, 31, 0, 1, then done; idx 0 data = 0.
- Backpressure: first=2, last=3, out_ready low for 5 cycles on word 2. Expect idx and data stable throughout. Write regfile[2]=0x12345678 during the stall; out_data keeps the old value. Word 3 follows after ready.
- Ignored start and reset mid-scan: pulse start with first=9 during a 0..31 scan; the scan is unaffected. Assert rst during PRESENT at idx 5. Next cycle all outputs are 0, no done pulse, and a new start works normally.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register file dump reader and its neighbours.
// Holds the scan FSM encoding and the register file geometry defaults.
// No logic; types and constants only.
package regfile_dump_reader_pkg;

    // Register file geometry shared with the pipeline's 32x32 regfile.
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // Scan FSM encoding, binary in 2 bits.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_out_reg.sv
// Output holding register for a debug tap: valid flag plus (index, data) word.
// Latency: load visible on the next edge; clear drops valid on the next edge.
// Backpressure: holds index/data unchanged until the owner issues clear.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears everything)
//   load                  capture load_idx/load_data and raise valid (wins over clear)
//   clear                 drop valid, keep the last word on idx/data
//   load_idx, load_data   word to capture
//   valid, idx, data      registered outputs
module regfile_dump_out_reg #(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            idx   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= load_idx;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a [first..last] register range (wrapping) through a spare read port, streaming (idx, data).
// Latency: first word valid 2 cycles after start; 1 word per 2 cycles; done at cycle 2N+1.
// Backpressure: holds the presented word indefinitely while out_ready is low; never stalls the pipeline.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, first, last             scan request and inclusive range, sampled only when idle
//   rd_addr, rd_data               spare combinational regfile read port
//   out_valid, out_ready           valid/ready handshake to the debug sink
//   out_idx, out_data              presented register index and snapshotted value
//   busy, done                     scan in progress; one-cycle completion pulse
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [ADDR_W-1:0] last_q;
    logic              busy_nxt;
    logic              latch_range;
    logic              out_load;
    logic              out_clear;
    logic              accept;

    assign accept = out_valid && out_ready;

    // The latched start index lives in rd_addr itself; only last needs its own register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_addr <= '0;
            busy    <= 1'b0;
            last_q  <= '0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            busy    <= busy_nxt;
            if (latch_range) begin
                last_q <= last;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        busy_nxt    = busy;
        latch_range = 1'b0;
        out_load    = 1'b0;
        out_clear   = 1'b0;
        done        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    latch_range = 1'b1;
                    rd_addr_nxt = first;
                    busy_nxt    = 1'b1;
                    state_nxt   = S_READ;
                end
            end
            S_READ: begin
                // Snapshot rd_data now; later regfile writes do not touch the presented word.
                out_load  = 1'b1;
                state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (accept) begin
                    out_clear = 1'b1;
                    if (out_idx == last_q) begin
                        state_nxt = S_DONE;
                    end else begin
                        // Next index from the presented one, wrapping modulo NUM_REGS.
                        rd_addr_nxt = (out_idx == ADDR_W'(NUM_REGS - 1)) ? '0 : out_idx + 1'b1;
                        state_nxt   = S_READ;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    regfile_dump_out_reg #(
        .IDX_W  (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (out_load),
        .clear     (out_clear),
        .load_idx  (rd_addr),
        .load_data (rd_data),
        .valid     (out_valid),
        .idx       (out_idx),
        .data      (out_data)
    );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader against a queue-based range model.
// Inputs driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// Cycle k after start means the values the k-th rising edge after the start edge samples.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];

    int n_checks;
    int n_fail;

    assign rd_data = rf[rd_addr];

    regfile_dump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first     (first),
        .last      (last),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one scan of [f..l] with the sink ready ready_pct% of cycles and checks the word stream
    // against the expected (index, value) list built by modular arithmetic over the range.
    task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input int ready_pct,
                            output int done_cyc, output int first_vld_cyc, output int nwords);
        logic [4:0]  exp_idx [$];
        logic [31:0] exp_dat [$];
        int          n;
        int          cyc;
        bit          finished;
        bit          pending;
        logic [4:0]  hold_idx;
        logic [31:0] hold_dat;
        logic [4:0]  ei;
        logic [31:0] ed;

        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int i = 0; i < n; i++) begin
            ei = 5'((int'(f) + i) % 32);
            exp_idx.push_back(ei);
            exp_dat.push_back(rf[ei]);
        end
        done_cyc = -1;
        first_vld_cyc = -1;
        nwords = 0;
        pending = 1'b0;
        hold_idx = '0;
        hold_dat = '0;
        finished = 1'b0;

        start = 1'b1;
        first = f;
        last  = l;
        @(negedge clk);
        start = 1'b0;
        first = $urandom;
        last  = $urandom;
        cyc = 1;
        while (!finished && cyc < 400) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (pending) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_idx !== hold_idx || out_data !== hold_dat)
                    $display("FAIL scan_hold: cyc %0d got v=%b idx=%0d data=%h, required v=1 idx=%0d data=%h",
                             cyc, out_valid, out_idx, out_data, hold_idx, hold_dat);
                if (out_valid !== 1'b1 || out_idx !== hold_idx || out_data !== hold_dat) n_fail++;
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_busy: cyc %0d got busy=%b, required 1", cyc, busy);
            end
            if (out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (exp_idx.size() == 0) begin
                    n_fail++;
                    $display("FAIL scan_extra_word: got idx=%0d data=%h, required no word", out_idx, out_data);
                end else begin
                    ei = exp_idx.pop_front();
                    ed = exp_dat.pop_front();
                    if (out_idx !== ei || out_data !== ed) begin
                        n_fail++;
                        $display("FAIL scan_word: got idx=%0d data=%h, required idx=%0d data=%h",
                                 out_idx, out_data, ei, ed);
                    end
                end
                nwords++;
            end
            pending  = (out_valid === 1'b1) && !out_ready;
            hold_idx = out_idx;
            hold_dat = out_data;
            if (done === 1'b1) begin
                done_cyc = cyc;
                finished = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL scan_timeout: got no done within %0d cycles, required done", cyc);
        end
        n_checks++;
        if (exp_idx.size() != 0) begin
            n_fail++;
            $display("FAIL scan_missing: got %0d words, required %0d", nwords, n);
        end
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_after_done: got busy=%b done=%b valid=%b, required 0 0 0", busy, done, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;   // start together with reset must be ignored
        first = 5'd4;
        last = 5'd6;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        n_checks++;
        if (out_idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d, required 0", out_idx); end
        n_checks++;
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", out_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++;
        if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d, required 0", rd_addr); end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: got busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_full_dump();
        int dc, fv, nw;
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h1111_1111;
        run_scan(5'd0, 5'd31, 100, dc, fv, nw);
        n_checks++;
        if (nw != 32) begin n_fail++; $display("FAIL full_count: got %0d, required 32", nw); end
        n_checks++;
        if (dc != 65) begin n_fail++; $display("FAIL full_done_cycle: got %0d, required 65", dc); end
        n_checks++;
        if (fv != 2) begin n_fail++; $display("FAIL full_first_valid: got %0d, required 2", fv); end
    endtask

    task automatic test_single();
        int dc, fv, nw;
        rf[7] = 32'hDEAD_BEEF;
        run_scan(5'd7, 5'd7, 100, dc, fv, nw);
        n_checks++;
        if (nw != 1 || dc != 3) begin
            n_fail++;
            $display("FAIL single: got words=%0d done_cyc=%0d, required 1 3", nw, dc);
        end
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_quiet: got valid=%b, required 0", out_valid); end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int dc, fv, nw;
        run_scan(5'd30, 5'd1, 100, dc, fv, nw);
        n_checks++;
        if (nw != 4 || dc != 9) begin
            n_fail++;
            $display("FAIL wrap: got words=%0d done_cyc=%0d, required 4 9", nw, dc);
        end
    endtask

    task automatic test_backpressure();
        int budget;
        rf[2] = 32'hAAAA_0002;
        rf[3] = 32'hBBBB_0003;
        out_ready = 1'b0;
        start = 1'b1;
        first = 5'd2;
        last = 5'd3;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (out_valid !== 1'b1 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_no_valid: got %b, required 1", out_valid); end
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 5'd2 || out_data !== 32'hAAAA_0002) begin
                n_fail++;
                $display("FAIL bp_stall: stall %0d got v=%b idx=%0d data=%h, required 1 2 aaaa0002",
                         s, out_valid, out_idx, out_data);
            end
            if (s == 1) rf[2] = 32'h1234_5678;
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_checks++;
        if (out_idx !== 5'd2 || out_data !== 32'hAAAA_0002) begin
            n_fail++;
            $display("FAIL bp_release: got idx=%0d data=%h, required 2 aaaa0002", out_idx, out_data);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_gap: got valid=%b, required 0", out_valid); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== 32'hBBBB_0003) begin
            n_fail++;
            $display("FAIL bp_word3: got v=%b idx=%0d data=%h, required 1 3 bbbb0003", out_valid, out_idx, out_data);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b, required 1", done); end
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got done=%b busy=%b, required 0 0", done, busy);
        end
        rf[2] = 32'hAAAA_0002;
    endtask

    task automatic test_ignored_start_and_reset();
        int cyc, expn, dc, fv, nw;
        bit hit;
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        out_ready = 1'b1;
        start = 1'b1;
        first = 5'd0;
        last = 5'd31;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        expn = 0;
        hit = 1'b0;
        while (!hit && cyc < 100) begin
            start = (cyc == 4);
            first = (cyc == 4) ? 5'd9 : 5'd0;
            last  = (cyc == 4) ? 5'd12 : 5'd0;
            if (out_valid === 1'b1 && out_idx === 5'd5) begin
                hit = 1'b1;
                rst = 1'b1;
                out_ready = 1'b0;
            end else begin
                if (out_valid === 1'b1) begin
                    n_checks++;
                    if (out_idx !== 5'(expn) || out_data !== rf[expn]) begin
                        n_fail++;
                        $display("FAIL ign_word: got idx=%0d data=%h, required idx=%0d data=%h",
                                 out_idx, out_data, expn, rf[expn]);
                    end
                    expn++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!hit || expn != 5) begin
            n_fail++;
            $display("FAIL ign_reach_idx5: got hit=%b words=%0d, required 1 5", hit, expn);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_idx !== 5'd0 || out_data !== 32'd0 ||
            busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b idx=%0d data=%h busy=%b done=%b rd=%0d, required all 0",
                     out_valid, out_idx, out_data, busy, done, rd_addr);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_quiet: got done=%b busy=%b valid=%b, required 0 0 0", done, busy, out_valid);
            end
        end
        run_scan(5'd3, 5'd4, 100, dc, fv, nw);
        n_checks++;
        if (nw != 2 || dc != 5) begin
            n_fail++;
            $display("FAIL restart: got words=%0d done_cyc=%0d, required 2 5", nw, dc);
        end
    endtask

    task automatic test_random_ranges();
        int dc, fv, nw, n, pct;
        logic [4:0] f, l;
        for (int t = 0; t < 8; t++) begin
            for (int i = 1; i < 32; i++) rf[i] = $urandom;
            f = 5'($urandom_range(0, 31));
            l = 5'($urandom_range(0, 31));
            n = ((int'(l) - int'(f) + 32) % 32) + 1;
            pct = (t % 2 == 0) ? 100 : 55;
            run_scan(f, l, pct, dc, fv, nw);
            n_checks++;
            if (nw != n) begin
                n_fail++;
                $display("FAIL rand_count: f=%0d l=%0d got %0d, required %0d", f, l, nw, n);
            end
            n_checks++;
            if ((pct == 100 && dc != 2 * n + 1) || dc < 2 * n + 1) begin
                n_fail++;
                $display("FAIL rand_done_cycle: f=%0d l=%0d ready=%0d got %0d, required %0d", f, l, pct, dc, 2 * n + 1);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        first = '0;
        last = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        @(negedge clk);
        test_reset();
        test_full_dump();
        test_single();
        test_wrap();
        test_backpressure();
        test_ignored_start_and_reset();
        test_random_ranges();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
